// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state encoding and byte-lane merge helper for the data memory
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BYTES-1:0]  mask
    );
        logic [WORD_W-1:0] r;
        for (int i = 0; i < BYTES; i++)
            r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if: load/store request bus between the core memory stage and the data memory
interface data_mem_unit_if import dmem_pkg::*;;
    logic [31:0]       dm_addr;
    logic [WORD_W-1:0] dm_data_in;
    logic [BYTES-1:0]  dm_wr_mask;
    logic              dm_wr_req;
    logic              dm_rd_req;
    logic [WORD_W-1:0] dm_data_o;
    logic              dm_ready;
    logic              dm_err;

    modport master (
        output dm_addr, dm_data_in, dm_wr_mask, dm_wr_req, dm_rd_req,
        input  dm_data_o, dm_ready, dm_err
    );

    modport slave (
        input  dm_addr, dm_data_in, dm_wr_mask, dm_wr_req, dm_rd_req,
        output dm_data_o, dm_ready, dm_err
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: word array with per-byte write enables, synchronous write, combinational read
module dmem_byte_ram import dmem_pkg::*; #(
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BYTES-1:0]  be_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [DEPTH];

    // merge enabled byte lanes into the addressed word; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= lane_merge(mem_q[addr_i], wdata_i, be_i);
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store data memory with wait-state handshake, byte-masked stores and range check
module data_mem_unit import dmem_pkg::*; #(
    parameter int MEM_DEPTH   = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_unit_if.slave  bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [29:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]  mask_q, mask_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              ready_q, ready_d, err_q, err_d;
    logic              oor, we;
    logic [WORD_W-1:0] rdata;

    assign oor = addr_q >= 30'(MEM_DEPTH);
    assign we  = (state_q == RESP) && wr_q && !oor;

    dmem_byte_ram #(.DEPTH(MEM_DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .be_i    (mask_q),
        .rdata_o (rdata)
    );

    // state, wait counter, request latches and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // accept in IDLE, count wait states in BUSY, complete the access in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_wr_req || bus.dm_rd_req) begin
                    addr_d  = bus.dm_addr[31:2];
                    wdata_d = bus.dm_data_in;
                    mask_d  = bus.dm_wr_mask;
                    wr_d    = bus.dm_wr_req;
                    rd_d    = bus.dm_rd_req;
                    state_d = (WAIT_STATES == 0) ? RESP : BUSY;
                    cnt_d   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
                end
            end
            BUSY: begin
                state_d = (cnt_q == 4'd0) ? RESP : BUSY;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                err_d   = oor || (wr_q && rd_q);
                if (rd_q && !wr_q)
                    dout_d = oor ? '0 : rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dm_data_o = dout_q;
    assign bus.dm_ready  = ready_q;
    assign bus.dm_err    = err_q;
endmodule
